// File: rtl/serdes_pkg.sv
// Constants shared by the serial transmitter and the matching bidirectional receiver.
package serdes_pkg;

   localparam logic DIR_RIGHT = 1'b1;   // LSB first
   localparam logic DIR_LEFT  = 1'b0;   // MSB first

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: loads an N-bit word over a valid/ready
// handshake and emits it one bit per shift_en strobe, LSB or MSB first.
module piso_serializer
   import serdes_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [N-1:0] load_data,
   input  logic         dir,
   input  logic         shift_en,
   output logic         serial_out,
   output logic         serial_valid,
   output logic         frame_done,
   output state_t       state_dbg
);

   localparam int CW = $clog2(N + 1);

   // Handshake: a word transfers on any cycle where load_valid and load_ready
   // are both high; load_ready never depends on load_valid, and the producer
   // must hold load_data/dir stable until that cycle.
   state_t         state;
   logic [CW-1:0]  cnt;
   logic [N-1:0]   shreg;
   logic           dir_q;
   logic           last_bit;
   logic           accept;

   assign last_bit     = (state == ST_SHIFT) && (cnt == CW'(1)) && shift_en;
   assign load_ready   = RST_N && ((state == ST_IDLE) || last_bit);
   assign accept       = load_valid && load_ready;
   assign serial_valid = RST_N && (state == ST_SHIFT);
   assign serial_out   = serial_valid && ((dir_q == DIR_RIGHT) ? shreg[0] : shreg[N-1]);
   assign state_dbg    = state;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         dir_q      <= DIR_LEFT;
         frame_done <= 1'b0;
      end else begin
         frame_done <= last_bit;
         if (accept) begin
            // Also covers the back-to-back reload on the old frame's last bit.
            state <= ST_SHIFT;
            cnt   <= CW'(N);
            dir_q <= dir;
         end else if ((state == ST_SHIFT) && shift_en) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1))
               state <= ST_IDLE;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         shreg <= '0;
      end else if (accept) begin
         shreg <= load_data;
      end else if ((state == ST_SHIFT) && shift_en) begin
         if (dir_q == DIR_RIGHT)
            shreg <= {1'b0, shreg[N-1:1]};
         else
            shreg <= {shreg[N-2:0], 1'b0};
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed plus randomized bench for piso_serializer with an in-bench
// receiver model that rebuilds each word from the observed serial stream.
module tb_piso_serializer;
   import serdes_pkg::*;

   localparam int N = 4;

   logic         CLK = 1'b0;
   logic         RST_N;
   logic         load_valid;
   logic         load_ready;
   logic [N-1:0] load_data;
   logic         dir;
   logic         shift_en;
   logic         serial_out;
   logic         serial_valid;
   logic         frame_done;
   state_t       state_dbg;

   int tests = 0;
   int fails = 0;

   logic [N-1:0] exp_q[$];

   piso_serializer #(.N(N)) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_data    (load_data),
      .dir          (dir),
      .shift_en     (shift_en),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .frame_done   (frame_done),
      .state_dbg    (state_dbg)
   );

   always #5 CLK = ~CLK;

   function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endfunction

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Bit i of the serial stream for a word, straight from the LSB/MSB-first rule.
   function automatic logic frame_bit(input logic [N-1:0] word, input logic d, input int i);
      return d ? word[i] : word[N-1-i];
   endfunction

   // Loads one word from IDLE, then drives shift_en from pat (LSB first, then
   // all ones), checking every cycle and rebuilding the word as a receiver would.
   task automatic run_frame(input logic [N-1:0] word, input logic d, input logic [15:0] pat);
      int           idx;
      int           p;
      logic         rx_bits[$];
      logic [N-1:0] rebuilt;
      load_valid = 1'b1;
      load_data  = word;
      dir        = d;
      shift_en   = 1'($urandom_range(0, 1));
      #1;
      check("idle_ready", load_ready, 1);
      check("idle_valid", serial_valid, 0);
      tick();
      idx = 0;
      p   = 0;
      while (idx < N) begin
         shift_en   = (p < 16) ? pat[p] : 1'b1;
         p++;
         load_data  = N'($urandom);
         dir        = 1'($urandom_range(0, 1));
         load_valid = (idx == N - 1) ? 1'b0 : 1'($urandom_range(0, 1));
         #1;
         check("busy_valid", serial_valid, 1);
         check("busy_bit", serial_out, frame_bit(word, d, idx));
         check("busy_done", frame_done, 0);
         check("busy_ready", load_ready, (idx == N - 1) && shift_en);
         if (shift_en) begin
            rx_bits.push_back(serial_out);
            idx++;
         end
         tick();
      end
      load_valid = 1'b0;
      shift_en   = 1'b0;
      #1;
      check("end_done", frame_done, 1);
      check("end_valid", serial_valid, 0);
      check("end_out", serial_out, 0);
      check("end_ready", load_ready, 1);
      tick();
      check("done_pulse", frame_done, 0);
      rebuilt = '0;
      for (int i = 0; i < N; i++)
         rebuilt[d ? i : N - 1 - i] = rx_bits[i];
      check("rx_word", rebuilt, word);
   endtask

   initial begin
      RST_N      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      dir        = 1'b0;
      shift_en   = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_ready", load_ready, 0);
      check("rst_valid", serial_valid, 0);
      check("rst_out", serial_out, 0);
      check("rst_done", frame_done, 0);
      check("rst_state", state_dbg, ST_IDLE);
      RST_N = 1'b1;
      #1;
      check("rel_ready", load_ready, 1);
      tick();

      // LSB first and MSB first of 1011, continuous strobe
      run_frame(4'b1011, 1'b1, 16'hFFFF);
      run_frame(4'b1011, 1'b0, 16'hFFFF);

      // Receiver loopback of 0110 in both directions
      run_frame(4'b0110, 1'b1, 16'hFFFF);
      run_frame(4'b0110, 1'b0, 16'hFFFF);

      // Strobe pattern 1,0,0,1,1,0,1 with gaps
      run_frame(4'b1011, 1'b1, 16'b1011001);
      run_frame(4'b1100, 1'b0, 16'b1011001);

      // Reset after two bits aborts the frame
      load_valid = 1'b1;
      load_data  = 4'b1001;
      dir        = 1'b1;
      shift_en   = 1'b1;
      tick();
      load_valid = 1'b0;
      tick();
      tick();
      RST_N = 1'b0;
      #1;
      check("abort_ready_in_rst", load_ready, 0);
      tick();
      check("abort_valid", serial_valid, 0);
      check("abort_ready", load_ready, 0);
      check("abort_done", frame_done, 0);
      RST_N = 1'b1;
      #1;
      check("abort_rel_ready", load_ready, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("abort_no_done", frame_done, 0);
         check("abort_idle", serial_valid, 0);
      end
      run_frame(4'b0111, 1'b0, 16'hFFFF);

      // Back-to-back A then 5, LSB first, contiguous stream
      exp_q.delete();
      exp_q.push_back(4'hA);
      exp_q.push_back(4'h5);
      begin
         logic bits[$];
         int   done_cyc[$];
         foreach (exp_q[w])
            for (int i = 0; i < N; i++)
               bits.push_back(frame_bit(exp_q[w], 1'b1, i));
         load_valid = 1'b1;
         load_data  = 4'hA;
         dir        = 1'b1;
         shift_en   = 1'b1;
         tick();
         load_data  = 4'h5;
         for (int c = 1; c <= 10; c++) begin
            if (c == 5)
               load_valid = 1'b0;
            #1;
            if (c <= 2 * N) begin
               check("b2b_valid", serial_valid, 1);
               check("b2b_bit", serial_out, bits[c - 1]);
            end else begin
               check("b2b_tail_valid", serial_valid, 0);
            end
            check("b2b_done", frame_done, (c == N + 1) || (c == 2 * N + 1));
            if (frame_done)
               done_cyc.push_back(c);
            tick();
         end
         check("b2b_done_count", done_cyc.size(), 2);
         if (done_cyc.size() == 2)
            check("b2b_done_gap", done_cyc[1] - done_cyc[0], N);
      end
      shift_en = 1'b0;
      tick();

      // Randomized frames
      for (int k = 0; k < 30; k++)
         run_frame(N'($urandom), 1'($urandom_range(0, 1)), 16'($urandom));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
